// File: rtl/fifo_sync_bram_pkg.sv
// fifo_sync_bram_pkg
// Shared sizing helpers for the synchronous BRAM-backed FIFO and its
// dual-port RAM. Both the controller and the RAM import this package so
// that depth, pointer width and the almost-full default are computed in
// exactly one place.
// Ports: none (package).

package fifo_sync_bram_pkg;

  // Number of words held by a RAM with the given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra bit above the RAM address so that a full
  // FIFO (pointers equal in address, different in lap) can be told apart
  // from an empty one.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Default almost-full threshold: two words short of full.
  function automatic int default_almost_full(input int addr_width);
    return fifo_depth(addr_width) - 2;
  endfunction

endpackage

// File: rtl/fifo_sync_bram_ram.sv
// bram_sync_dp
// Dual-port block RAM with a two-stage registered read path on port B.
// This variant is intended for a common clock: a_clk and b_clk must be
// driven by the same clock, which lets both ports' writes share a single
// memory-update process.
// Ports:
//   a_clk, b_clk    : port clocks (same clock)
//   rst             : async active-high reset of the read pipeline only
//   a_wr            : port A write strobe
//   a_addr          : port A address
//   a_data_in       : port A write data
//   b_en            : port B access enable
//   b_wr            : port B write strobe (read when low)
//   b_addr          : port B address
//   b_data_in       : port B write data
//   b_data_out      : port B read data, holds until the next read completes

module bram_sync_dp
  import fifo_sync_bram_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      a_clk,
  input  logic                      b_clk,
  input  logic                      rst,
  input  logic                      a_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_DATA_WIDTH-1:0] a_data_in,
  input  logic                      b_en,
  input  logic                      b_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_DATA_WIDTH-1:0] b_data_in,
  output logic [RAM_DATA_WIDTH-1:0] b_data_out
);

  localparam int RAM_DEPTH = fifo_depth(RAM_ADDR_WIDTH);

  logic [RAM_DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_DATA_WIDTH-1:0] rd_q;
  logic                      rd_q_valid;
  logic                      b_rd;

  assign b_rd = b_en & ~b_wr;

  // Memory array update. Port A wins if both ports write in the same
  // cycle; the FIFO never drives a port B write, so this only matters
  // for other users of the RAM.
  always_ff @(posedge a_clk) begin
    if (a_wr) begin
      mem[a_addr] <= a_data_in;
    end else if (b_en && b_wr) begin
      mem[b_addr] <= b_data_in;
    end
  end

  // Read pipeline: the array is sampled into rd_q on the read edge and
  // moved to the output register on the following edge. The output only
  // updates when a read actually completes, so it holds the last word
  // read in between.
  always_ff @(posedge b_clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      rd_q_valid <= 1'b0;
      b_data_out <= '0;
    end else begin
      rd_q_valid <= b_rd;
      if (b_rd) begin
        rd_q <= mem[b_addr];
      end
      if (rd_q_valid) begin
        b_data_out <= rd_q;
      end
    end
  end

endmodule

// File: rtl/fifo_sync_bram.sv
// fifo_sync_bram
// Single-clock FIFO controller around a bram_sync_dp instance. Port A of
// the RAM is the write port, port B the read port. The controller owns
// the pointers, occupancy count and all status flags.
// Ports:
//   clk          : clock, also drives both RAM port clocks
//   rst          : async active-high reset
//   wr_en        : write request
//   data_in      : write data
//   rd_en        : read request
//   data_out     : read data (RAM port B output)
//   data_valid   : data_out holds a newly read word this cycle
//   empty        : occupancy == 0
//   full         : occupancy == DEPTH
//   almost_full  : occupancy >= ALMOST_FULL
//   count        : current occupancy
//   overflow     : one-cycle pulse after a rejected write
//   underflow    : one-cycle pulse after a rejected read

module fifo_sync_bram
  import fifo_sync_bram_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ALMOST_FULL = default_almost_full(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(ALMOST_FULL);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] count_next;
  logic             wr_acc;
  logic             rd_acc;
  logic             rd_acc_d;

  // Acceptance uses this cycle's registered flags. When full, the write
  // is refused even if a read frees a slot this cycle; that keeps port A
  // from ever writing the address port B is reading.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Occupancy after this edge; the flags are registered from this value
  // so they line up with count.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + PTR_ONE;
      2'b01:   count_next = count - PTR_ONE;
      default: count_next = count;
    endcase
  end

  // Pointer and occupancy registers. Pointers wrap naturally modulo
  // 2*DEPTH; their low bits wrap modulo DEPTH as RAM addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Status flags and the rejected-request pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH_LVL);
      almost_full <= (count_next >= AF_LVL);
      overflow    <= wr_en & full;
      underflow   <= rd_en & empty;
    end
  end

  // The RAM read path is two registers deep, so data_valid is the
  // accepted-read strobe delayed by two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_acc_d   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      rd_acc_d   <= rd_acc;
      data_valid <= rd_acc_d;
    end
  end

  bram_sync_dp #(
    .RAM_DATA_WIDTH (DATA_WIDTH),
    .RAM_ADDR_WIDTH (ADDR_WIDTH)
  ) ram (
    .a_clk      (clk),
    .b_clk      (clk),
    .rst        (rst),
    .a_wr       (wr_acc),
    .a_addr     (wptr[ADDR_WIDTH-1:0]),
    .a_data_in  (data_in),
    .b_en       (rd_acc),
    .b_wr       (1'b0),
    .b_addr     (rptr[ADDR_WIDTH-1:0]),
    .b_data_in  ({DATA_WIDTH{1'b0}}),
    .b_data_out (data_out)
  );

endmodule

// File: tb/tb_fifo_sync_bram.sv
// tb_fifo_sync_bram
// Directed self-checking bench for fifo_sync_bram at default parameters
// (8-bit data, 16 words, almost-full at 14).

module tb_fifo_sync_bram;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checkCount = 0;
  int errorCount = 0;

  fifo_sync_bram dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the request inputs for the next edge.
  task automatic applyStimulus(input logic w, input int d, input logic r);
    wr_en   = w;
    data_in = 8'(d);
    rd_en   = r;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write n words base, base+1, ... starting from occupancy start.
  task automatic fill(input int n, input int base, input int start);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, base + i, 1'b0);
      tick();
      checkOutput("fill_count", int'(count), start + i + 1);
      checkOutput("fill_almost_full", int'(almost_full), (start + i + 1 >= 14) ? 1 : 0);
      checkOutput("fill_full", int'(full), (start + i + 1 == 16) ? 1 : 0);
    end
    applyStimulus(1'b0, 0, 1'b0);
  endtask

  // Read n words with rd_en held and expect base, base+1, ... on
  // consecutive cycles with data_valid continuously high.
  task automatic drain(input int n, input int base);
    applyStimulus(1'b0, 0, 1'b1);
    tick();
    checkOutput("drain_first_valid", int'(data_valid), 0);
    for (int j = 0; j < n; j++) begin
      if (j == n - 1) applyStimulus(1'b0, 0, 1'b0);
      tick();
      checkOutput("drain_data", int'(data_out), (base + j) & 8'hFF);
      checkOutput("drain_valid", int'(data_valid), 1);
    end
    checkOutput("drain_empty", int'(empty), 1);
    checkOutput("drain_count", int'(count), 0);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);

    // Reset held for three edges.
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_almost_full", int'(almost_full), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_valid", int'(data_valid), 0);
    checkOutput("rst_data", int'(data_out), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_underflow", int'(underflow), 0);

    // Fill with 0x00..0x0F, then drain in order; data_out holds afterwards.
    fill(16, 0, 0);
    drain(16, 0);
    tick();
    checkOutput("hold_valid", int'(data_valid), 0);
    checkOutput("hold_data", int'(data_out), 8'h0F);

    // Overflow: write 0xAA into a full FIFO.
    fill(16, 8'h10, 0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tick();
    checkOutput("ovf_pulse", int'(overflow), 1);
    checkOutput("ovf_count", int'(count), 16);
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    checkOutput("ovf_pulse_end", int'(overflow), 0);
    drain(16, 8'h10);

    // Empty with both requests: write taken, read rejected.
    applyStimulus(1'b1, 8'h33, 1'b1);
    tick();
    checkOutput("both_empty_count", int'(count), 1);
    checkOutput("both_empty_underflow", int'(underflow), 1);
    checkOutput("both_empty_empty", int'(empty), 0);
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    checkOutput("both_empty_underflow_end", int'(underflow), 0);

    // Full with both requests: read taken, write rejected.
    fill(15, 8'h40, 1);
    applyStimulus(1'b1, 8'h77, 1'b1);
    tick();
    checkOutput("both_full_count", int'(count), 15);
    checkOutput("both_full_overflow", int'(overflow), 1);
    checkOutput("both_full_full", int'(full), 0);
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    checkOutput("both_full_data", int'(data_out), 8'h33);
    checkOutput("both_full_valid", int'(data_valid), 1);
    checkOutput("both_full_overflow_end", int'(overflow), 0);
    drain(15, 8'h40);

    // Streaming at occupancy 5 for 40 cycles; addresses wrap repeatedly.
    fill(5, 0, 0);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 5 + c, 1'b1);
      tick();
      checkOutput("stream_count", int'(count), 5);
      if (c == 0) begin
        checkOutput("stream_first_valid", int'(data_valid), 0);
      end else begin
        checkOutput("stream_data", int'(data_out), c - 1);
        checkOutput("stream_valid", int'(data_valid), 1);
      end
    end
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    checkOutput("stream_last_data", int'(data_out), 39);
    checkOutput("stream_last_valid", int'(data_valid), 1);
    drain(5, 40);

    // Asynchronous reset between edges at occupancy 9.
    fill(9, 8'h60, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_empty", int'(empty), 1);
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_full", int'(full), 0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'h5C, 1'b0);
    tick();
    checkOutput("midrst_write_count", int'(count), 1);
    applyStimulus(1'b0, 0, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    checkOutput("midrst_read_data", int'(data_out), 8'h5C);
    checkOutput("midrst_read_valid", int'(data_valid), 1);
    checkOutput("midrst_read_empty", int'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
